// File: rtl/mem_io_responder_pkg.sv
// Shared constants, I/O register decode and types for the memory/I/O responder.
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL_BITS        = 2'b11;
    localparam logic [17:0] IO_UART_ADDR       = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR        = 18'h30004;
    localparam int          ADDR_WIDTH_DEFAULT = 17;
    localparam int          RAM_BYTES          = 1 << ADDR_WIDTH_DEFAULT;

    // Which I/O register an 18-bit bus address selects.
    typedef enum logic [2:0] {
        IO_NONE,
        IO_UART,
        IO_CLK_B0,
        IO_CLK_B1,
        IO_CLK_B2,
        IO_CLK_B3
    } io_reg_e;

    // Map an address inside the I/O window to its register; anything else is IO_NONE.
    function automatic io_reg_e io_decode(input logic [17:0] a);
        io_reg_e r;
        r = IO_NONE;
        if (a == IO_UART_ADDR) begin
            r = IO_UART;
        end else if (a[17:2] == IO_CLK_ADDR[17:2]) begin
            case (a[1:0])
                2'd0:    r = IO_CLK_B0;
                2'd1:    r = IO_CLK_B1;
                2'd2:    r = IO_CLK_B2;
                default: r = IO_CLK_B3;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory port: address/data/strobe from the CPU, read data and
// back-pressure from the responder.
interface mem_io_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO used as the UART transmit queue.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop,
    output logic [7:0]    o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count_next
);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Next-state occupancy; also feeds the registered near-full flag upstream.
    always_comb begin
        o_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            o_count_next = r_count + CW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            o_count_next = r_count - CW'(1);
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and count update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Bus-side responder for the CPU memory port: 2^ADDR_WIDTH bytes of RAM with
// one-cycle read latency, plus memory-mapped UART and cycle-counter/halt I/O.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_pop,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                halt
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int CW        = $clog2(TX_DEPTH) + 1;

    logic [7:0]            r_ram [RAM_DEPTH];
    logic [7:0]            r_mem_din;
    logic [31:0]           r_cnt;
    logic [31:0]           r_snap;
    logic                  r_halt;
    logic                  r_io_full;

    logic [17:0]           w_io_addr;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_io_sel;
    io_reg_e               w_io_reg;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ram_wr;
    logic                  w_uart_rd;
    logic                  w_io_wr_ok;
    logic                  w_halt_wr;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_tx_pop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [CW-1:0]         w_count_next;

    assign w_io_addr  = bus.mem_a[17:0];
    assign w_ram_addr = bus.mem_a[ADDR_WIDTH-1:0];
    assign w_io_sel   = (w_io_addr[17:16] == IO_SEL_BITS);
    assign w_io_reg   = io_decode(w_io_addr);
    assign w_rd       = bus.rdy_in && !bus.mem_wr;
    assign w_wr       = bus.rdy_in && bus.mem_wr;
    assign w_ram_wr   = w_wr && !w_io_sel;
    assign w_uart_rd  = w_rd && w_io_sel && (w_io_reg == IO_UART);
    assign w_io_wr_ok = w_wr && w_io_sel && !r_halt;
    assign w_halt_wr  = w_io_wr_ok && (w_io_reg == IO_CLK_B0);

    // The received byte is consumed in the same cycle that its read is presented.
    assign rx_pop   = rst_in && w_uart_rd && rx_valid;

    assign tx_valid = !w_fifo_empty;
    assign w_tx_pop = tx_valid && tx_ready;

    assign bus.mem_din        = r_mem_din;
    assign bus.io_buffer_full = r_io_full;
    assign halt               = r_halt;

    // TX push selection: UART writes drop 0x00; the halt write pushes 0x00 as an end marker.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = bus.mem_dout;
        if (w_io_wr_ok) begin
            if (w_io_reg == IO_UART && bus.mem_dout != 8'h00) begin
                w_push = 1'b1;
            end else if (w_io_reg == IO_CLK_B0) begin
                w_push      = 1'b1;
                w_push_data = 8'h00;
            end
        end
    end

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .i_push       (w_push && (!w_fifo_full || w_tx_pop)),
        .i_din        (w_push_data),
        .i_pop        (w_tx_pop),
        .o_dout       (tx_data),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full),
        .o_count_next (w_count_next)
    );

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_addr] <= bus.mem_dout;
        end
    end

    // Read data register; counter byte 0 latches a snapshot so bytes 1..3 stay coherent.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem_din <= 8'h00;
            r_snap    <= 32'h0;
        end else if (w_rd) begin
            if (w_io_sel) begin
                case (w_io_reg)
                    IO_UART:   r_mem_din <= rx_valid ? rx_data : 8'h00;
                    IO_CLK_B0: begin
                        r_mem_din <= r_cnt[7:0];
                        r_snap    <= r_cnt;
                    end
                    IO_CLK_B1: r_mem_din <= r_snap[15:8];
                    IO_CLK_B2: r_mem_din <= r_snap[23:16];
                    IO_CLK_B3: r_mem_din <= r_snap[31:24];
                    default:   r_mem_din <= 8'h00;
                endcase
            end else begin
                r_mem_din <= r_ram[w_ram_addr];
            end
        end
    end

    // Free-running cycle counter, sticky halt and registered near-full flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt     <= 32'h0;
            r_halt    <= 1'b0;
            r_io_full <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 32'h1;
            r_io_full <= (CW'(TX_DEPTH) - w_count_next) <= CW'(FULL_MARGIN);
            if (w_halt_wr) begin
                r_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, UART RX/TX, counter snapshot,
// TX back-pressure, halt and asynchronous reset.
module tb_mem_io_responder;

    logic       clk;
    logic       rst_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       halt;

    int n_checks;
    int n_fail;

    logic [7:0] txq[$];

    mem_io_responder_if bus ();

    mem_io_responder #(
        .ADDR_WIDTH  (17),
        .TX_DEPTH    (8),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .bus      (bus.slave),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_pop   (rx_pop),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    // Record every byte the UART side accepts.
    always @(posedge clk) begin
        if (rst_in && tx_valid && tx_ready) begin
            txq.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic bus_op(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = 1'b1;
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.mem_dout = d;
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.rdy_in = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && tx_valid; i++) @(negedge clk);
        check("drain_done", {31'h0, tx_valid}, 32'h0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        clk          = 1'b0;
        rst_in       = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        tx_ready     = 1'b0;
        bus.rdy_in   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
        #1;
        check("rst_mem_din",  {24'h0, bus.mem_din}, 32'h0);
        check("rst_rx_pop",   {31'h0, rx_pop}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_halt",     {31'h0, halt}, 32'h0);
        check("rst_io_full",  {31'h0, bus.io_buffer_full}, 32'h0);

        // Counter snapshot across the 0xFF -> 0x100 carry
        do_reset();
        repeat (255) @(negedge clk);
        bus_op(1'b0, 32'h30004, 8'h00); check("cnt_b0", {24'h0, bus.mem_din}, 32'hFF);
        bus_op(1'b0, 32'h30005, 8'h00); check("cnt_b1", {24'h0, bus.mem_din}, 32'h00);
        bus_op(1'b0, 32'h30006, 8'h00); check("cnt_b2", {24'h0, bus.mem_din}, 32'h00);
        bus_op(1'b0, 32'h30007, 8'h00); check("cnt_b3", {24'h0, bus.mem_din}, 32'h00);
        bus_op(1'b0, 32'h30004, 8'h00); check("cnt2_b0", {24'h0, bus.mem_din}, 32'h03);
        bus_op(1'b0, 32'h30005, 8'h00); check("cnt2_b1", {24'h0, bus.mem_din}, 32'h01);

        // RAM write/read, top address, rdy_in low, unmapped I/O
        bus_op(1'b1, 32'h00010, 8'hA5);
        bus_op(1'b0, 32'h00010, 8'h00); check("ram_10", {24'h0, bus.mem_din}, 32'hA5);
        bus_op(1'b1, 32'h1FFFF, 8'hC3);
        bus_op(1'b0, 32'h1FFFF, 8'h00); check("ram_1ffff", {24'h0, bus.mem_din}, 32'hC3);
        bus.rdy_in = 1'b0; bus.mem_wr = 1'b1; bus.mem_a = 32'h00010; bus.mem_dout = 8'h5A;
        @(negedge clk);
        check("rdy_low_hold", {24'h0, bus.mem_din}, 32'hC3);
        bus_op(1'b0, 32'h00010, 8'h00); check("rdy_low_nowr", {24'h0, bus.mem_din}, 32'hA5);
        bus_op(1'b0, 32'h30008, 8'h00); check("io_other", {24'h0, bus.mem_din}, 32'h00);
        bus_idle();

        // UART receive
        rx_valid = 1'b1; rx_data = 8'h41;
        bus.rdy_in = 1'b1; bus.mem_wr = 1'b0; bus.mem_a = 32'h30000;
        #1 check("rx_pop_hi", {31'h0, rx_pop}, 32'h1);
        @(negedge clk);
        check("rx_data", {24'h0, bus.mem_din}, 32'h41);
        bus_idle();
        #1 check("rx_pop_1cyc", {31'h0, rx_pop}, 32'h0);
        rx_valid = 1'b0;
        bus.rdy_in = 1'b1; bus.mem_wr = 1'b0; bus.mem_a = 32'h30000;
        #1 check("rx_nopop", {31'h0, rx_pop}, 32'h0);
        @(negedge clk);
        check("rx_empty", {24'h0, bus.mem_din}, 32'h00);
        bus_idle();

        // UART transmit with zero filter
        txq.delete();
        tx_ready = 1'b1;
        bus_op(1'b1, 32'h30000, 8'h48);
        bus_op(1'b1, 32'h30000, 8'h00);
        bus_op(1'b1, 32'h30000, 8'h69);
        bus_idle();
        wait_drain();
        check("tx_seq_n",  txq.size(), 32'd2);
        check("tx_seq_0",  {24'h0, txq[0]}, 32'h48);
        check("tx_seq_1",  {24'h0, txq[1]}, 32'h69);

        // Back-pressure: near-full after 6, 9th push dropped
        txq.delete();
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus_op(1'b1, 32'h30000, 8'(i));
            if (i == 5) check("full_after5", {31'h0, bus.io_buffer_full}, 32'h0);
            if (i == 6) check("full_after6", {31'h0, bus.io_buffer_full}, 32'h1);
        end
        bus_idle();
        tx_ready = 1'b1;
        wait_drain();
        check("full_drain_n", txq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_drain_%0d", i), {24'h0, txq[i]}, 32'(i + 1));
        end
        check("full_clear", {31'h0, bus.io_buffer_full}, 32'h0);

        // Halt: marker byte, later I/O writes ignored, RAM still works
        txq.delete();
        tx_ready = 1'b0;
        bus_op(1'b1, 32'h30000, 8'h11);
        bus_op(1'b1, 32'h30000, 8'h22);
        bus_op(1'b1, 32'h30000, 8'h33);
        bus_op(1'b1, 32'h30004, 8'hAB);
        check("halt_set", {31'h0, halt}, 32'h1);
        bus_op(1'b1, 32'h30000, 8'h55);
        bus_op(1'b1, 32'h00020, 8'h3C);
        bus_op(1'b0, 32'h00020, 8'h00); check("ram_after_halt", {24'h0, bus.mem_din}, 32'h3C);
        bus_idle();
        tx_ready = 1'b1;
        wait_drain();
        check("halt_tx_n", txq.size(), 32'd4);
        check("halt_tx_0", {24'h0, txq[0]}, 32'h11);
        check("halt_tx_1", {24'h0, txq[1]}, 32'h22);
        check("halt_tx_2", {24'h0, txq[2]}, 32'h33);
        check("halt_tx_3", {24'h0, txq[3]}, 32'h00);

        // Asynchronous reset in the middle of a drain
        do_reset();
        txq.delete();
        tx_ready = 1'b0;
        bus_op(1'b1, 32'h30000, 8'h77);
        bus_op(1'b1, 32'h30000, 8'h88);
        bus_op(1'b1, 32'h30004, 8'h00);
        bus_idle();
        tx_ready = 1'b1;
        @(negedge clk);
        check("mid_drain_valid", {31'h0, tx_valid}, 32'h1);
        check("mid_drain_first", {24'h0, txq[0]}, 32'h77);
        rst_in = 1'b0;
        #1;
        check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("arst_halt",     {31'h0, halt}, 32'h0);
        check("arst_io_full",  {31'h0, bus.io_buffer_full}, 32'h0);
        check("arst_mem_din",  {24'h0, bus.mem_din}, 32'h0);
        @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
